// File: rtl/snn_spike_stream_arbiter.sv
// Round-robin merge of NUM_SOURCES AXI-Stream spike streams into one SNN layer input.
// Ports: clk/reset (async, active-high), enable, s_axis_* per-source slave streams,
//   m_axis_* merged registered master stream, grant_src, frame_done pulse, event/frame counters.
module snn_spike_stream_arbiter #(
  parameter int NUM_SOURCES  = 4,
  parameter int SRC_W        = 2,
  parameter int CHANNEL_STEP = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [32*NUM_SOURCES-1:0] s_axis_tdata,
  input  logic [NUM_SOURCES-1:0]   s_axis_tvalid,
  output logic [NUM_SOURCES-1:0]   s_axis_tready,
  input  logic [NUM_SOURCES-1:0]   s_axis_tlast,
  output logic [31:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [SRC_W-1:0]         grant_src,
  output logic                     frame_done,
  output logic [31:0]              event_count,
  output logic [15:0]              frame_count
);

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  localparam logic [NUM_SOURCES-1:0] ALL_ONES = {NUM_SOURCES{1'b1}};
  localparam logic [NUM_SOURCES-1:0] ONE      = {{(NUM_SOURCES-1){1'b0}}, 1'b1};
  localparam logic [SRC_W-1:0]       LAST_IDX = SRC_W'(NUM_SOURCES - 1);

  state_t                 state_q, state_d;
  logic [31:0]            m_tdata_q;
  logic                   m_tvalid_q;
  logic                   m_tlast_q;
  logic [SRC_W-1:0]       grant_q;
  logic                   frame_done_q;
  logic [31:0]            event_cnt_q;
  logic [15:0]            frame_cnt_q;
  logic [NUM_SOURCES-1:0] done_mask_q;
  logic [SRC_W-1:0]       rr_ptr_q;

  logic [NUM_SOURCES-1:0] elig;
  logic [NUM_SOURCES-1:0] gnt_onehot;
  logic [SRC_W-1:0]       gnt_idx;
  logic                   gnt_found;
  logic                   slot_free;
  logic                   in_hs;
  logic                   out_hs;
  logic [31:0]            sel_dat;
  logic                   sel_last;
  logic [15:0]            ch_off;
  logic                   frame_end;
  logic                   flush_done;

  assign elig      = s_axis_tvalid & ~done_mask_q;
  assign slot_free = !m_tvalid_q || m_axis_tready;
  assign out_hs    = m_tvalid_q && m_axis_tready;

  // First eligible source at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (!gnt_found && elig[(int'(rr_ptr_q) + k) % NUM_SOURCES]) begin
        gnt_found = 1'b1;
        gnt_idx   = SRC_W'((int'(rr_ptr_q) + k) % NUM_SOURCES);
      end
    end
  end

  assign gnt_onehot = ONE << gnt_idx;

  // Ready is forced low while reset is asserted so no beat is accepted into a clearing register.
  assign in_hs         = !reset && (state_q == ST_RUN) && enable && slot_free && gnt_found;
  assign s_axis_tready = in_hs ? gnt_onehot : '0;

  assign sel_dat  = s_axis_tdata[32*gnt_idx +: 32];
  assign sel_last = s_axis_tlast[gnt_idx];
  assign ch_off   = 16'(int'(gnt_idx) * CHANNEL_STEP);

  // The merged frame ends only on a tlast beat that completes the mask; a plain beat from the
  // last unmasked source does not close the frame.
  assign frame_end  = sel_last && ((done_mask_q | gnt_onehot) == ALL_ONES);
  assign flush_done = (state_q == ST_FLUSH) && out_hs;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (in_hs && frame_end) state_d = ST_FLUSH;
      ST_FLUSH: if (out_hs) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tdata_q    <= '0;
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      grant_q      <= '0;
      frame_done_q <= 1'b0;
      event_cnt_q  <= '0;
      frame_cnt_q  <= '0;
      done_mask_q  <= '0;
      rr_ptr_q     <= '0;
    end else begin
      frame_done_q <= flush_done;
      if (out_hs) event_cnt_q <= event_cnt_q + 32'd1;

      // Fill takes priority over drain so a beat can leave and enter in the same cycle.
      if (in_hs) begin
        m_tdata_q   <= {sel_dat[31:16] + ch_off, sel_dat[15:0]};
        m_tvalid_q  <= 1'b1;
        m_tlast_q   <= frame_end;
        grant_q     <= gnt_idx;
        rr_ptr_q    <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        done_mask_q <= done_mask_q | (sel_last ? gnt_onehot : '0);
      end else if (out_hs) begin
        m_tvalid_q <= 1'b0;
        m_tlast_q  <= 1'b0;
      end

      // No input is accepted in ST_FLUSH, so this never collides with a mask set above.
      if (flush_done) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        done_mask_q <= '0;
      end
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign grant_src     = grant_q;
  assign frame_done    = frame_done_q;
  assign event_count   = event_cnt_q;
  assign frame_count   = frame_cnt_q;

endmodule

// File: tb/tb_snn_spike_stream_arbiter.sv
module tb_snn_spike_stream_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [127:0] s_tdata;
  logic [3:0]   s_tvalid;
  logic [3:0]   s_tready;
  logic [3:0]   s_tlast;
  logic [31:0]  m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic [1:0]   grant_src;
  logic         frame_done;
  logic [31:0]  event_count;
  logic [15:0]  frame_count;

  snn_spike_stream_arbiter #(.NUM_SOURCES(4), .SRC_W(2), .CHANNEL_STEP(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .grant_src(grant_src), .frame_done(frame_done),
    .event_count(event_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Source model: per-source beat memory {last, ch, pos} with read/write pointers.
  logic [32:0] src_mem [4][32];
  int          wr_p [4];
  int          rd_p [4];

  always_comb begin
    s_tvalid = '0;
    s_tdata  = '0;
    s_tlast  = '0;
    for (int i = 0; i < 4; i++) begin
      s_tvalid[i]        = rd_p[i] < wr_p[i];
      s_tdata[32*i +: 32] = src_mem[i][rd_p[i] % 32][31:0];
      s_tlast[i]         = src_mem[i][rd_p[i] % 32][32];
    end
  end

  logic [3:0] hs;
  always begin
    @(negedge clk);
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) rd_p[i] = rd_p[i] + 1;
  end

  task automatic load(input int s, input logic [15:0] ch, input logic [15:0] pos, input logic last);
    src_mem[s][wr_p[s] % 32] = {last, ch, pos};
    wr_p[s] = wr_p[s] + 1;
  endtask

  typedef struct packed {
    logic [1:0]  g;
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t exp_q[$];

  task automatic expect_beat(input logic [1:0] g, input logic [15:0] ch, input logic [15:0] pos,
                             input logic last);
    exp_t e;
    e.g = g;
    e.d = {ch, pos};
    e.l = last;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every master handshake seen at the falling edge.
  logic expect_fd = 1'b0;
  int   fd_cnt = 0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_done) fd_cnt++;
      if (expect_fd) begin
        check("frame_done_after_tlast", {31'd0, frame_done}, 32'd1);
        expect_fd = 1'b0;
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", m_tdata, 32'hDEAD_BEEF);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", m_tdata, mon_e.d);
          check("beat_last", {31'd0, m_tlast}, {31'd0, mon_e.l});
          check("beat_grant", {30'd0, grant_src}, {30'd0, mon_e.g});
        end
        if (m_tlast) expect_fd = 1'b1;
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, exp_q.size(), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int viol;
    logic seen_b;
    logic got_fd;
    for (int i = 0; i < 4; i++) begin
      wr_p[i] = 0;
      rd_p[i] = 0;
    end
    reset    = 1'b1;
    enable   = 1'b1;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_counts", {event_count[15:0], frame_count}, 32'd0);
    check("rst_ready", {28'd0, s_tready}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Round-robin with all four valid: channels 1,17,33,49.
    for (int i = 0; i < 4; i++) load(i, 16'd1, 16'(10 + i), 1'b0);
    expect_beat(2'd0, 16'd1, 16'd10, 1'b0);
    expect_beat(2'd1, 16'd17, 16'd11, 1'b0);
    expect_beat(2'd2, 16'd33, 16'd12, 1'b0);
    expect_beat(2'd3, 16'd49, 16'd13, 1'b0);
    repeat (5) tick();
    check("event_count_after_5", event_count, 32'd4);
    wait_drain("drain_rr");

    // Backpressure: beat from source 0 held three cycles, then source 1 granted on release.
    m_tready = 1'b0;
    load(0, 16'd2, 16'd20, 1'b0);
    load(1, 16'd3, 16'd21, 1'b0);
    expect_beat(2'd0, 16'd2, 16'd20, 1'b0);
    expect_beat(2'd1, 16'd19, 16'd21, 1'b0);
    tick();
    for (int c = 0; c < 3; c++) begin
      check("bp_tvalid", {31'd0, m_tvalid}, 32'd1);
      check("bp_tdata", m_tdata, {16'd2, 16'd20});
      check("bp_ready", {28'd0, s_tready}, 32'd0);
      tick();
    end
    m_tready = 1'b1;
    #1;
    check("bp_release_ready", {28'd0, s_tready}, 32'd2);
    wait_drain("drain_bp");
    check("bp_event_count", event_count, 32'd6);

    // Frame end: 2,1,3,1 beats starting from rr_ptr=2.
    for (int f = 0; f < 2; f++) begin
      load(0, 16'd0, 16'd100, 1'b0); load(0, 16'd0, 16'd101, 1'b1);
      load(1, 16'd0, 16'd110, 1'b1);
      load(2, 16'd0, 16'd120, 1'b0); load(2, 16'd0, 16'd121, 1'b0); load(2, 16'd0, 16'd122, 1'b1);
      load(3, 16'd0, 16'd130, 1'b1);
      if (f == 0) begin
        expect_beat(2'd2, 16'd32, 16'd120, 1'b0);
        expect_beat(2'd3, 16'd48, 16'd130, 1'b0);
        expect_beat(2'd0, 16'd0, 16'd100, 1'b0);
        expect_beat(2'd1, 16'd16, 16'd110, 1'b0);
        expect_beat(2'd2, 16'd32, 16'd121, 1'b0);
        expect_beat(2'd0, 16'd0, 16'd101, 1'b0);
        expect_beat(2'd2, 16'd32, 16'd122, 1'b1);
      end else begin
        expect_beat(2'd3, 16'd48, 16'd130, 1'b0);
        expect_beat(2'd0, 16'd0, 16'd100, 1'b0);
        expect_beat(2'd1, 16'd16, 16'd110, 1'b0);
        expect_beat(2'd2, 16'd32, 16'd120, 1'b0);
        expect_beat(2'd0, 16'd0, 16'd101, 1'b0);
        expect_beat(2'd2, 16'd32, 16'd121, 1'b0);
        expect_beat(2'd2, 16'd32, 16'd122, 1'b1);
      end
      wait_drain("drain_frame");
      tick();
      check("frame_count", {16'd0, frame_count}, 32'(f + 1));
      check("frame_done_pulses", fd_cnt, 32'(f + 1));
    end

    // Masking: source 1 finishes early and keeps presenting its next-frame beat.
    for (int k = 0; k < 3; k++) begin
      load(0, 16'd0, 16'(300 + k), k == 2);
      load(2, 16'd0, 16'(320 + k), k == 2);
      load(3, 16'd0, 16'(330 + k), k == 2);
    end
    load(1, 16'd0, 16'd200, 1'b1);
    load(1, 16'd0, 16'd201, 1'b0);
    expect_beat(2'd3, 16'd48, 16'd330, 1'b0);
    expect_beat(2'd0, 16'd0, 16'd300, 1'b0);
    expect_beat(2'd1, 16'd16, 16'd200, 1'b0);
    expect_beat(2'd2, 16'd32, 16'd320, 1'b0);
    expect_beat(2'd3, 16'd48, 16'd331, 1'b0);
    expect_beat(2'd0, 16'd0, 16'd301, 1'b0);
    expect_beat(2'd2, 16'd32, 16'd321, 1'b0);
    expect_beat(2'd3, 16'd48, 16'd332, 1'b0);
    expect_beat(2'd0, 16'd0, 16'd302, 1'b0);
    expect_beat(2'd2, 16'd32, 16'd322, 1'b1);
    expect_beat(2'd1, 16'd16, 16'd201, 1'b0);
    viol   = 0;
    seen_b = 1'b0;
    got_fd = 1'b0;
    for (int c = 0; c < 100 && !got_fd; c++) begin
      @(negedge clk);
      if (frame_done) got_fd = 1'b1;
      else begin
        if (seen_b && s_tready[1]) viol++;
        if (m_tvalid && grant_src == 2'd1) seen_b = 1'b1;
      end
    end
    check("mask_frame_done_seen", {31'd0, got_fd}, 32'd1);
    check("mask_src1_seen", {31'd0, seen_b}, 32'd1);
    check("mask_ready_held_low", viol, 32'd0);
    tick();
    wait_drain("drain_mask");

    // Enable low: no accept, then accepted once enabled.
    enable = 1'b0;
    load(2, 16'd0, 16'd600, 1'b0);
    #1;
    check("en_low_ready", {28'd0, s_tready}, 32'd0);
    tick();
    tick();
    check("en_low_no_beat", {31'd0, m_tvalid}, 32'd0);
    expect_beat(2'd2, 16'd32, 16'd600, 1'b0);
    enable = 1'b1;
    wait_drain("drain_enable");

    // Channel wrap on source 3.
    load(3, 16'hFFF5, 16'd7, 1'b0);
    expect_beat(2'd3, 16'h0025, 16'd7, 1'b0);
    wait_drain("drain_wrap");

    // Reset mid-frame with done_mask=0101 and a beat held.
    load(0, 16'd0, 16'd500, 1'b1);
    load(1, 16'd0, 16'd501, 1'b0);
    load(2, 16'd0, 16'd502, 1'b1);
    load(3, 16'd0, 16'd503, 1'b0);
    expect_beat(2'd0, 16'd0, 16'd500, 1'b0);
    expect_beat(2'd1, 16'd16, 16'd501, 1'b0);
    expect_beat(2'd2, 16'd32, 16'd502, 1'b0);
    expect_beat(2'd3, 16'd48, 16'd503, 1'b0);
    wait_drain("drain_pre_reset");
    m_tready = 1'b0;
    load(1, 16'd0, 16'd504, 1'b0);
    tick();
    check("held_before_reset", {29'd0, m_tvalid, grant_src}, 32'h5);
    #2;
    reset = 1'b1;
    #1;
    check("arst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("arst_tdata", m_tdata, 32'd0);
    check("arst_grant_last", {29'd0, m_tlast, grant_src}, 32'd0);
    check("arst_counts", {event_count[15:0], frame_count}, 32'd0);
    check("arst_ready", {28'd0, s_tready}, 32'd0);
    for (int i = 0; i < 4; i++) rd_p[i] = wr_p[i];
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    tick();
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) load(i, 16'd3, 16'(400 + i), 1'b1);
    expect_beat(2'd0, 16'd3, 16'd400, 1'b0);
    expect_beat(2'd1, 16'd19, 16'd401, 1'b0);
    expect_beat(2'd2, 16'd35, 16'd402, 1'b0);
    expect_beat(2'd3, 16'd51, 16'd403, 1'b1);
    #1;
    check("post_reset_first_grant", {28'd0, s_tready}, 32'd1);
    wait_drain("drain_post_reset");
    tick();
    check("post_reset_frame_count", {16'd0, frame_count}, 32'd1);
    check("post_reset_event_count", event_count, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
